// File: rtl/baby_serial_accumulator.sv
// SSEM accumulator stage: executes LDN/SUB bit-serially (LSB first, borrow flop), CMP/NOP in one cycle.
// Optional BABY_ACC_PARALLEL_EN replaces the serial EXEC phase with a single word-parallel subtract.
module baby_serial_accumulator #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] operand,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] acc,
  output logic             negative,
  output logic             skip
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    OP_LDN = 2'b00,
    OP_SUB = 2'b01,
    OP_CMP = 2'b10,
    OP_NOP = 2'b11
  } opcode_t;

  state_t           state, nextState;
  opcode_t          opCode;
  logic [WIDTH-1:0] accReg;
  logic [WIDTH-1:0] wReg;
  logic [WIDTH-1:0] sReg;
  logic             skipReg;

`ifndef BABY_ACC_PARALLEL_EN
  localparam int CW = $clog2(WIDTH);

  logic [CW-1:0]    count;
  logic             borrow;
  logic             diffBit;
  logic             borrowNext;
  logic             lastBit;
`endif

  assign opCode = opcode_t'(op);

  always_comb begin
    nextState = state;
`ifndef BABY_ACC_PARALLEL_EN
    diffBit    = wReg[0] ^ sReg[0] ^ borrow;
    borrowNext = (~wReg[0] & sReg[0]) | (~(wReg[0] ^ sReg[0]) & borrow);
    lastBit    = (count == CW'(WIDTH - 1));
`endif
    unique case (state)
      IDLE: begin
        if (start) begin
          if (opCode == OP_LDN || opCode == OP_SUB) nextState = EXEC;
          else                                      nextState = DONE;
        end
      end
      EXEC: begin
`ifndef BABY_ACC_PARALLEL_EN
        if (lastBit) nextState = DONE;
`else
        nextState = DONE;
`endif
      end
      DONE:    nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      accReg  <= '0;
      wReg    <= '0;
      sReg    <= '0;
      skipReg <= 1'b0;
`ifndef BABY_ACC_PARALLEL_EN
      count   <= '0;
      borrow  <= 1'b0;
`endif
    end else begin
      state <= nextState;
      unique case (state)
        IDLE: begin
          if (start) begin
            unique case (opCode)
              OP_LDN, OP_SUB: begin
                sReg    <= operand;
                wReg    <= (opCode == OP_SUB) ? accReg : '0;
                skipReg <= 1'b0;
`ifndef BABY_ACC_PARALLEL_EN
                borrow  <= 1'b0;
                count   <= '0;
`endif
              end
              OP_CMP: skipReg <= accReg[WIDTH-1];
              OP_NOP: skipReg <= 1'b0;
              default: skipReg <= 1'b0;
            endcase
          end
        end
        EXEC: begin
`ifndef BABY_ACC_PARALLEL_EN
          // Difference bits enter at the MSB so W holds the full result after WIDTH shifts.
          wReg   <= {diffBit, wReg[WIDTH-1:1]};
          sReg   <= sReg >> 1;
          borrow <= borrowNext;
          count  <= count + 1'b1;
          if (lastBit) accReg <= {diffBit, wReg[WIDTH-1:1]};
`else
          accReg <= wReg - sReg;
`endif
        end
        default: ;
      endcase
    end
  end

  assign busy     = (state == EXEC);
  assign done     = (state == DONE);
  assign acc      = accReg;
  assign negative = accReg[WIDTH-1];
  assign skip     = skipReg;

endmodule

// File: tb/tb_baby_serial_accumulator.sv
// Self-checking bench for baby_serial_accumulator (WIDTH=32): vector table, scoreboard queue, corner sequences.
module tb_baby_serial_accumulator;

  localparam int WIDTH = 32;
`ifdef BABY_ACC_PARALLEL_EN
  localparam int EXEC_CYCLES = 1;
`else
  localparam int EXEC_CYCLES = WIDTH;
`endif
  localparam int PULSE_AT = (EXEC_CYCLES < 5) ? EXEC_CYCLES : 5;
  localparam int RESET_AT = (EXEC_CYCLES < 10) ? EXEC_CYCLES : 10;

  logic             clock;
  logic             reset;
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] operand;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] acc;
  logic             negative;
  logic             skip;

  baby_serial_accumulator #(.WIDTH(WIDTH)) dut (
    .clock    (clock),
    .reset    (reset),
    .start    (start),
    .op       (op),
    .operand  (operand),
    .busy     (busy),
    .done     (done),
    .acc      (acc),
    .negative (negative),
    .skip     (skip)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] operand;
    logic [31:0] expAcc;
    logic        expSkip;
  } vec_t;

  typedef struct {
    logic [31:0] acc;
    logic        skip;
    int          lat;
    int          busyCycles;
  } exp_t;

  exp_t        sb[$];
  vec_t        vecs[12];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] mAcc   = '0;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  task automatic pushExp(input logic [1:0] o, input logic [31:0] ea, input logic es);
    exp_t e;
    e.acc        = ea;
    e.skip       = es;
    e.lat        = (o <= 2'b01) ? EXEC_CYCLES + 1 : 1;
    e.busyCycles = (o <= 2'b01) ? EXEC_CYCLES : 0;
    sb.push_back(e);
  endtask

  task automatic driveStart(input logic [1:0] o, input logic [31:0] v);
    @(negedge clock);
    op      = o;
    operand = v;
    start   = 1'b1;
    @(posedge clock);
    #1;
    start   = 1'b0;
    op      = 2'($urandom);
    operand = $urandom;
  endtask

  task automatic compareResult(input string nm, input bit seen, input int lat, input int busyN, input bit stable);
    exp_t e;
    e = sb.pop_front();
    check({nm, ".timeout"}, 32'(seen), 32'd1);
    check({nm, ".latency"}, lat, e.lat);
    check({nm, ".busyCycles"}, busyN, e.busyCycles);
    check({nm, ".busyAtDone"}, 32'(busy), 32'd0);
    check({nm, ".accStable"}, 32'(stable), 32'd1);
    check({nm, ".acc"}, acc, e.acc);
    check({nm, ".negative"}, 32'(negative), 32'(e.acc[31]));
    check({nm, ".skip"}, 32'(skip), 32'(e.skip));
  endtask

  task automatic runOp(input logic [1:0] o, input logic [31:0] v, input logic [31:0] ea,
                       input logic es, input string nm);
    logic [31:0] accBefore;
    bit          seen;
    bit          stable;
    int          lat;
    int          busyN;
    accBefore = acc;
    pushExp(o, ea, es);
    driveStart(o, v);
    seen = 0; stable = 1; lat = 0; busyN = 0;
    for (int c = 1; c <= 100 && !seen; c++) begin
      @(negedge clock);
      if (busy) begin
        busyN++;
        if (acc !== accBefore) stable = 0;
      end
      if (done) begin
        seen = 1;
        lat  = c;
      end
    end
    compareResult(nm, seen, lat, busyN, stable);
    mAcc = ea;
  endtask

  initial begin
    vecs[0]  = '{2'b00, 32'h0000_0005, 32'hFFFF_FFFB, 1'b0};
    vecs[1]  = '{2'b01, 32'hFFFF_FFFA, 32'h0000_0001, 1'b0};
    vecs[2]  = '{2'b00, 32'h0000_0000, 32'h0000_0000, 1'b0};
    vecs[3]  = '{2'b00, 32'h8000_0000, 32'h8000_0000, 1'b0};
    vecs[4]  = '{2'b01, 32'h0000_0001, 32'h7FFF_FFFF, 1'b0};
    vecs[5]  = '{2'b00, 32'h0000_0005, 32'hFFFF_FFFB, 1'b0};
    vecs[6]  = '{2'b10, 32'hDEAD_BEEF, 32'hFFFF_FFFB, 1'b1};
    vecs[7]  = '{2'b11, 32'hDEAD_BEEF, 32'hFFFF_FFFB, 1'b0};
    vecs[8]  = '{2'b00, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0};
    vecs[9]  = '{2'b10, 32'h1234_5678, 32'h0000_0001, 1'b0};
    vecs[10] = '{2'b01, 32'h1234_5678, 32'hEDCB_A989, 1'b0};
    vecs[11] = '{2'b10, 32'h0000_0000, 32'hEDCB_A989, 1'b1};

    reset = 1'b1; start = 1'b0; op = '0; operand = '0;
    repeat (3) @(negedge clock);
    check("reset.acc",  acc, 32'h0);
    check("reset.busy", 32'(busy), 32'd0);
    check("reset.done", 32'(done), 32'd0);
    check("reset.skip", 32'(skip), 32'd0);
    reset = 1'b0;
    @(negedge clock);

    for (int i = 0; i < 12; i++)
      runOp(vecs[i].op, vecs[i].operand, vecs[i].expAcc, vecs[i].expSkip, $sformatf("vec%0d", i));

    // skip stays set until the next accepted start
    repeat (4) @(negedge clock);
    check("skipHeld", 32'(skip), 32'd1);
    runOp(2'b00, 32'h0000_0000, 32'h0000_0000, 1'b0, "clearSkip");

    for (int i = 0; i < 6; i++) begin
      logic [31:0] v;
      logic [1:0]  o;
      logic [31:0] ea;
      v  = $urandom;
      o  = 2'($urandom_range(0, 1));
      ea = (o == 2'b01) ? mAcc - v : 32'h0 - v;
      runOp(o, v, ea, 1'b0, $sformatf("rand%0d", i));
    end

    begin : ignoredStarts
      bit seen;
      bit stable;
      bit pulsed;
      int lat;
      int busyN;
      pushExp(2'b00, 32'hFFFF_FFF9, 1'b0);
      driveStart(2'b00, 32'h0000_0007);
      seen = 0; stable = 1; pulsed = 0; lat = 0; busyN = 0;
      for (int c = 1; c <= 100 && !seen; c++) begin
        @(negedge clock);
        if (busy) begin
          busyN++;
          if (acc !== mAcc) stable = 0;
        end
        if (done) begin
          seen = 1;
          lat  = c;
        end else if (busy && busyN == PULSE_AT && !pulsed) begin
          pulsed = 1;
          start = 1'b1; op = 2'b00; operand = 32'h0000_0003;
          @(posedge clock);
          #1 start = 1'b0;
        end
      end
      check("ign.pulsedWhileBusy", 32'(pulsed), 32'd1);
      compareResult("ign", seen, lat, busyN, stable);
      start = 1'b1; op = 2'b00; operand = 32'h0000_0003;
      @(negedge clock);
      start = 1'b0;
      check("ign.idleBusy", 32'(busy), 32'd0);
      check("ign.idleDone", 32'(done), 32'd0);
      @(negedge clock);
      check("ign.stillIdle", 32'(busy), 32'd0);
      check("ign.acc", acc, 32'hFFFF_FFF9);
      mAcc = 32'hFFFF_FFF9;
    end

    runOp(2'b01, 32'h0000_0002, 32'hFFFF_FFF7, 1'b0, "b2bA");
    runOp(2'b10, 32'h0000_0000, 32'hFFFF_FFF7, 1'b1, "b2bB");
    runOp(2'b00, 32'h0000_0005, 32'hFFFF_FFFB, 1'b0, "b2bC");

    begin : midReset
      bit hit;
      int busyN;
      hit = 0; busyN = 0;
      driveStart(2'b01, 32'h0000_0011);
      for (int c = 1; c <= 100 && !hit; c++) begin
        @(negedge clock);
        if (busy) busyN++;
        if (busy && busyN == RESET_AT) begin
          hit = 1;
          #2 reset = 1'b1;
          #1;
          check("midReset.acc",  acc, 32'h0);
          check("midReset.busy", 32'(busy), 32'd0);
          check("midReset.done", 32'(done), 32'd0);
          check("midReset.skip", 32'(skip), 32'd0);
        end
      end
      check("midReset.reached", 32'(hit), 32'd1);
      @(negedge clock);
      reset = 1'b0;
      mAcc  = '0;
      repeat (2) @(negedge clock);
      check("midReset.noDone", 32'(done), 32'd0);
      runOp(2'b00, 32'h0000_0005, 32'hFFFF_FFFB, 1'b0, "postReset");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/baby_serial_accumulator.md
Name: baby_serial_accumulator

Overview:
- Accumulator stage for the SSEM datapath; consumes memory words and executes LDN, SUB and CMP.
- Keeps the Baby's bit-serial arithmetic: one bit per clock, LSB first, with a borrow flip-flop. It is the sequential counterpart of the word-parallel subtractor.
- Sits downstream of store read-out and upstream of the control unit, which uses done/skip to advance the CI.

Parameters:
- WIDTH, 32, accumulator and operand word width (>=2).

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous active-high reset.
- start  in  1  request; sampled only in IDLE.
- op  in  2  00 LDN (A = 0 - S), 01 SUB (A = A - S), 10 CMP (skip if A<0), 11 NOP.
- operand  in  WIDTH  store word S; sampled on the start edge.
- busy  out  1  high while serial execution is in progress.
- done  out  1  one-cycle completion pulse.
- acc  out  WIDTH  architectural accumulator A.
- negative  out  1  equals acc[WIDTH-1].
- skip  out  1  CMP result; held until the next accepted start.

Behaviour:
- Reset (async, any state): acc=0, busy=0, done=0, skip=0, state=IDLE, bit counter=0, borrow=0, working registers=0. Reset mid-operation aborts; no partial result reaches acc.
- States: IDLE, EXEC, DONE.
- IDLE:
  - start=1 with op=00 or 01: latch operand into shift register S.
  - Working register W = acc for SUB, W = 0 for LDN.
  - Set borrow=0, counter=0, skip=0. Next state EXEC.
- IDLE, start=1 with op=10: skip <= acc[WIDTH-1]. Next state DONE.
- IDLE, start=1 with op=11: skip <= 0. Next state DONE.
- EXEC, each cycle:
  - d = W[0] XOR S[0] XOR borrow.
  - borrow <= (~W[0] & S[0]) | (~(W[0] XOR S[0]) & borrow).
  - W shifts right, inserting d at the MSB. S shifts right.
  - counter++.
  - After WIDTH cycles (counter == WIDTH-1 on the edge): acc <= final W, next state DONE.
- Timing: busy=1 for exactly WIDTH cycles, starting the cycle after start is accepted.
- DONE: done=1 for one cycle, busy=0, then IDLE. A new start is accepted no earlier than the cycle after done.
- Outputs during an operation: acc is updated only at completion and stays stable throughout EXEC. negative tracks acc combinationally.
- start while busy or in DONE is ignored; no queuing.
- Arithmetic:
  - Modulo 2^WIDTH two's complement; the final borrow is discarded.
  - 0x80000000 - 1 = 0x7FFFFFFF.
  - LDN of 0x80000000 = 0x80000000.
- Latency from start edge to done:
  - LDN/SUB: WIDTH+1 cycles.
  - CMP/NOP: 1 cycle.
- op and operand are don't-care except in the start-accept cycle.

Optional Feature:
- Macro: BABY_ACC_PARALLEL_EN.
- Defined:
  - EXEC lasts exactly 1 cycle and computes W - S as a word-parallel subtract.
  - busy is high for 1 cycle; LDN/SUB latency is 2 cycles.
  - Results are bit-identical to the serial path.
- Undefined: bit-serial datapath as described above.
- Interface is identical in both builds.

Test Plan (WIDTH=32):
- Reset: assert reset mid-run at bit 10 of a SUB -> acc=0, busy=0, done=0, skip=0 immediately. After release the next LDN behaves normally.
- LDN: operand=5 -> busy high 32 cycles, then done pulse; acc=0xFFFFFFFB, negative=1. Also LDN 0 -> acc=0.
- SUB: acc=0xFFFFFFFB, operand=0xFFFFFFFA -> acc=0x00000001, negative=0. Wrap case: acc=0x80000000, operand=1 -> acc=0x7FFFFFFF.
- CMP: acc=0xFFFFFFFB -> done 1 cycle after start, skip=1 held. Then CMP with acc=1 -> skip=0. NOP -> skip=0, acc unchanged.
- Ignored start: pulse start with op=00 while busy (cycle 5) and in DONE -> no effect; acc equals the first operation's result. Back-to-back starts in the cycle after done both complete.
- Parallel build: repeat the LDN/SUB vectors with BABY_ACC_PARALLEL_EN defined -> identical acc values, busy high 1 cycle, done 2 cycles after start.
